mm_bram_parallel_ctrl: RTL and testbench

Sequencing controller for the parallel BRAM matrix-multiply datapath. On `start` it streams every row address of the source SRAM, aligns `dpath_sum_en` and `dpath_result_wraddr` with the returned row data, and counts result writebacks from the datapath. It raises `done` once all `ROW_NUM` result rows have been written. It sits between the top-level command interface, the source SRAM read port and the datapath control inputs.

---
 rtl/mm_bram_parallel_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mm_bram_parallel_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_bram_parallel_ctrl.sv
// -----------------------------------------------------------------------------
// mm_bram_parallel_ctrl
//
// Sequencing controller for the parallel BRAM matrix-multiply datapath.
// A job is requested with `start`. The controller then streams every row
// address of the source SRAM in order. A delay line matched to the SRAM read
// latency carries each read forward, so that `dpath_sum_en` and
// `dpath_result_wraddr` line up with the returned row data. The controller
// counts result writebacks from the datapath and pulses `done` once all
// ROW_NUM rows have been written back.
//
// Ports
//   clk                  single clock, rising edge
//   reset                synchronous, active-low; clears all state
//   start                job request, sampled only in IDLE
//   hold                 stall; blocks new read issue while high
//   busy                 high in ISSUE and DRAIN
//   done                 one-cycle pulse in the DONE state
//   err                  sticky writeback-overflow flag, cleared by an accepted start
//   src_rd_en            source SRAM read enable
//   src_rd_addr          source SRAM read row
//   dpath_sum_en         row data valid at the datapath this cycle
//   dpath_result_wraddr  result row tag for the data presented
//   wb_val               writeback strobe from the datapath (column 0 enable)
// -----------------------------------------------------------------------------
module mm_bram_parallel_ctrl #(
  parameter  int ROW_NUM        = 32,
  parameter  int SRAM_RD_LAT    = 1,
  localparam int ROW_ADDR_WIDTH = $clog2(ROW_NUM)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      hold,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      src_rd_en,
  output logic [ROW_ADDR_WIDTH-1:0] src_rd_addr,
  output logic                      dpath_sum_en,
  output logic [ROW_ADDR_WIDTH-1:0] dpath_result_wraddr,
  input  logic                      wb_val
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [ROW_ADDR_WIDTH-1:0] LAST_ROW   = ROW_ADDR_WIDTH'(ROW_NUM - 1);
  localparam logic [ROW_ADDR_WIDTH:0]   ROW_NUM_WB = (ROW_ADDR_WIDTH + 1)'(ROW_NUM);

  state_e                    state_q, state_d;
  logic [ROW_ADDR_WIDTH-1:0] issue_cnt_q, issue_cnt_d;
  logic [ROW_ADDR_WIDTH:0]   wb_cnt_q, wb_cnt_d;
  logic                      err_q, err_d;

  // Read-alignment delay line; index 0 is the newest entry.
  logic [SRAM_RD_LAT-1:0]    pipe_en_q;
  logic [ROW_ADDR_WIDTH-1:0] pipe_addr_q [SRAM_RD_LAT];

  logic active;
  logic wb_full;

  assign active  = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign wb_full = (wb_cnt_q == ROW_NUM_WB);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    wb_cnt_d    = wb_cnt_q;
    err_d       = err_q;
    src_rd_en   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_ISSUE;
          issue_cnt_d = '0;
          wb_cnt_d    = '0;
        end
      end
      S_ISSUE: begin
        if (!hold) begin
          src_rd_en = 1'b1;
          // The counter is cleared on the last row instead of wrapping, so
          // the address bus idles at row 0 when ROW_NUM is not a power of two.
          if (issue_cnt_q == LAST_ROW) begin
            issue_cnt_d = '0;
            state_d     = S_DRAIN;
          end else begin
            issue_cnt_d = issue_cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Writebacks may already arrive during ISSUE for short jobs or deep stalls.
    if (active && wb_val && !wb_full) begin
      wb_cnt_d = wb_cnt_q + 1'b1;
    end

    // Use the updated count so DONE follows the last writeback edge directly.
    if ((state_q == S_DRAIN) && (wb_cnt_d == ROW_NUM_WB)) begin
      state_d = S_DONE;
    end

    if ((state_q == S_IDLE) && start) begin
      err_d = 1'b0;
    end else if (wb_val && (!active || wb_full)) begin
      err_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!reset) begin
      state_q     <= S_IDLE;
      issue_cnt_q <= '0;
      wb_cnt_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      wb_cnt_q    <= wb_cnt_d;
      err_q       <= err_d;
    end
  end

  // The delay line shifts every cycle, so reads already issued complete
  // even under hold or after the FSM has left ISSUE.
  always_ff @(posedge clk) begin
    // NOTE: this small array is reset on purpose: a reset mid-job must flush
    // in-flight reads so no stray dpath_sum_en follows the reset edge.
    if (!reset) begin
      for (int i = 0; i < SRAM_RD_LAT; i++) begin
        pipe_en_q[i]   <= 1'b0;
        pipe_addr_q[i] <= '0;
      end
    end else begin
      for (int i = SRAM_RD_LAT - 1; i > 0; i--) begin
        pipe_en_q[i]   <= pipe_en_q[i-1];
        pipe_addr_q[i] <= pipe_addr_q[i-1];
      end
      pipe_en_q[0]   <= src_rd_en;
      pipe_addr_q[0] <= issue_cnt_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign src_rd_addr         = issue_cnt_q;
  assign dpath_sum_en        = pipe_en_q[SRAM_RD_LAT-1];
  assign dpath_result_wraddr = pipe_addr_q[SRAM_RD_LAT-1];
  assign busy                = active;
  assign done                = (state_q == S_DONE);
  assign err                 = err_q;

endmodule

// File: tb/tb_mm_bram_parallel_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mm_bram_parallel_ctrl
//
// Two controllers share clock, reset, start, hold and an overflow-injection
// strobe:
//   lane A: SRAM_RD_LAT=1 feeding a datapath model with writeback latency 3
//   lane B: SRAM_RD_LAT=3 feeding a datapath model with writeback latency 1
// Both lanes then see their last writeback in the same cycle, so one
// expected timeline covers both. That timeline is derived from the hold
// plan: row k is issued in the k-th non-held cycle after start. Its sum
// enable follows after SRAM_RD_LAT cycles and its writeback 4 cycles after
// issue, and done comes one cycle after the last writeback.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_mm_bram_parallel_ctrl;

  localparam int ROW_NUM = 4;
  localparam int AW      = 2;
  localparam int PLAN_N  = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic hold = 1'b0;
  logic inject = 1'b0;

  logic          busy_a, done_a, err_a, rd_en_a, sum_a, wb_a;
  logic [AW-1:0] addr_a, wr_a;
  logic          busy_b, done_b, err_b, rd_en_b, sum_b, wb_b;
  logic [AW-1:0] addr_b, wr_b;

  logic [2:0] dp_pipe_a;
  logic       dp_pipe_b;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_err  = 1'b0;
  bit hold_plan [PLAN_N];

  always #5 clk = ~clk;

  mm_bram_parallel_ctrl #(.ROW_NUM(ROW_NUM), .SRAM_RD_LAT(1)) u_dut_a (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .hold                (hold),
    .busy                (busy_a),
    .done                (done_a),
    .err                 (err_a),
    .src_rd_en           (rd_en_a),
    .src_rd_addr         (addr_a),
    .dpath_sum_en        (sum_a),
    .dpath_result_wraddr (wr_a),
    .wb_val              (wb_a)
  );

  mm_bram_parallel_ctrl #(.ROW_NUM(ROW_NUM), .SRAM_RD_LAT(3)) u_dut_b (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .hold                (hold),
    .busy                (busy_b),
    .done                (done_b),
    .err                 (err_b),
    .src_rd_en           (rd_en_b),
    .src_rd_addr         (addr_b),
    .dpath_sum_en        (sum_b),
    .dpath_result_wraddr (wr_b),
    .wb_val              (wb_b)
  );

  // Datapath models: writeback follows each sum enable by a fixed latency.
  // The datapath shares the controller reset.
  always @(posedge clk) begin
    if (!reset) begin
      dp_pipe_a <= '0;
      dp_pipe_b <= 1'b0;
    end else begin
      dp_pipe_a <= {dp_pipe_a[1:0], sum_a};
      dp_pipe_b <= sum_b;
    end
  end

  assign wb_a = dp_pipe_a[2] | inject;
  assign wb_b = dp_pipe_b | inject;

  function automatic logic [9:0] obs_ctrl();
    return {busy_a, done_a, err_a, rd_en_a, sum_a,
            busy_b, done_b, err_b, rd_en_b, sum_b};
  endfunction

  task automatic clear_plan();
    for (int c = 0; c < PLAN_N; c++) hold_plan[c] = 1'b0;
  endtask

  // One job from start to DONE. Entry and exit are 1 time unit after a
  // rising edge; on exit the controller should be in its first IDLE cycle.
  task automatic run_job(input string tag, input bit start_in_issue,
                         input bit start_in_done, input bit wb_in_done);
    int            iss [ROW_NUM];
    int            k;
    int            tw;
    bit            e_rd, e_sa, e_sb, e_busy, e_done, e_err;
    int            r_rd, r_sa, r_sb;
    logic [9:0]    exp_v;
    k = 0;
    for (int c = 1; c < PLAN_N; c++) begin
      if (k < ROW_NUM && !hold_plan[c]) begin
        iss[k] = c;
        k++;
      end
    end
    tw = iss[ROW_NUM-1] + 4;
    for (int c = 0; c <= tw + 1; c++) begin
      e_rd = 1'b0; e_sa = 1'b0; e_sb = 1'b0;
      r_rd = 0;    r_sa = 0;    r_sb = 0;
      for (int j = 0; j < ROW_NUM; j++) begin
        if (c == iss[j])     begin e_rd = 1'b1; r_rd = j; end
        if (c == iss[j] + 1) begin e_sa = 1'b1; r_sa = j; end
        if (c == iss[j] + 3) begin e_sb = 1'b1; r_sb = j; end
      end
      e_busy = (c >= 1) && (c <= tw);
      e_done = (c == tw + 1);
      e_err  = (c == 0) ? exp_err : 1'b0;
      start  = (c == 0) || (start_in_issue && c == 2) || (start_in_done && c == tw + 1);
      hold   = (c < PLAN_N) ? hold_plan[c] : 1'b0;
      inject = wb_in_done && (c == tw + 1);
      @(negedge clk);
      exp_v = {e_busy, e_done, e_err, e_rd, e_sa, e_busy, e_done, e_err, e_rd, e_sb};
      n_checks++;
      if (obs_ctrl() !== exp_v) begin
        n_fail++;
        $display("FAIL %s ctrl cycle %0d: got %b expected %b (busy,done,err,rd_en,sum_en x lanes A,B)",
                 tag, c, obs_ctrl(), exp_v);
      end
      if (e_rd) begin
        n_checks++;
        if (addr_a !== AW'(r_rd) || addr_b !== AW'(r_rd)) begin
          n_fail++;
          $display("FAIL %s rd_addr cycle %0d: got A=%0d B=%0d expected %0d", tag, c, addr_a, addr_b, r_rd);
        end
      end
      if (e_sa) begin
        n_checks++;
        if (wr_a !== AW'(r_sa)) begin
          n_fail++;
          $display("FAIL %s wraddr_A cycle %0d: got %0d expected %0d", tag, c, wr_a, r_sa);
        end
      end
      if (e_sb) begin
        n_checks++;
        if (wr_b !== AW'(r_sb)) begin
          n_fail++;
          $display("FAIL %s wraddr_B cycle %0d: got %0d expected %0d", tag, c, wr_b, r_sb);
        end
      end
      @(posedge clk); #1;
    end
    start   = 1'b0;
    hold    = 1'b0;
    inject  = 1'b0;
    exp_err = wb_in_done;
  endtask

  task automatic idle_cycles(input string tag, input int n);
    logic [9:0] exp_v;
    for (int c = 0; c < n; c++) begin
      start = 1'b0;
      @(negedge clk);
      exp_v = {3'b000, 2'b00, 3'b000, 2'b00};
      exp_v[7] = exp_err;
      exp_v[2] = exp_err;
      n_checks++;
      if (obs_ctrl() !== exp_v) begin
        n_fail++;
        $display("FAIL %s idle cycle %0d: got %b expected %b", tag, c, obs_ctrl(), exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({obs_ctrl(), addr_a, wr_a, addr_b, wr_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got %b expected all zero", {obs_ctrl(), addr_a, wr_a, addr_b, wr_b});
    end
    @(posedge clk); #1;
    reset   = 1'b1;
    exp_err = 1'b0;
    idle_cycles("reset_idle", 2);
  endtask

  task automatic test_basic();
    clear_plan();
    run_job("basic", 1'b0, 1'b0, 1'b0);
    idle_cycles("basic_after", 2);
  endtask

  task automatic test_hold();
    clear_plan();
    // Row 1 is issued in cycle 2; stall for the next three cycles.
    for (int c = 3; c <= 5; c++) hold_plan[c] = 1'b1;
    run_job("hold", 1'b0, 1'b0, 1'b0);
    idle_cycles("hold_after", 1);
  endtask

  task automatic test_random_hold();
    for (int job = 0; job < 6; job++) begin
      clear_plan();
      for (int c = 1; c < 20; c++) hold_plan[c] = ($urandom_range(0, 99) < 45);
      run_job($sformatf("rand_hold_%0d", job), 1'b0, 1'b0, 1'b0);
      idle_cycles("rand_after", $urandom_range(0, 2));
    end
  endtask

  task automatic test_start_while_busy();
    clear_plan();
    hold_plan[2] = 1'b1;
    run_job("start_busy", 1'b1, 1'b1, 1'b0);
    idle_cycles("start_busy_after", 4);
  endtask

  task automatic test_overflow();
    // Writeback in IDLE sets err.
    inject = 1'b1;
    @(posedge clk); #1;
    inject  = 1'b0;
    exp_err = 1'b1;
    idle_cycles("ovf_idle", 3);
    // Accepted start clears it; a writeback in DONE sets it again.
    clear_plan();
    run_job("ovf_done", 1'b0, 1'b0, 1'b1);
    idle_cycles("ovf_sticky", 3);
    run_job("ovf_clear", 1'b0, 1'b0, 1'b0);
    idle_cycles("ovf_clear_after", 1);
  endtask

  task automatic test_back_to_back();
    clear_plan();
    run_job("b2b_first", 1'b0, 1'b0, 1'b0);
    hold_plan[3] = 1'b1;
    run_job("b2b_second", 1'b0, 1'b0, 1'b0);
    idle_cycles("b2b_after", 2);
  endtask

  task automatic test_mid_reset();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if (rd_en_a !== 1'b1 || addr_a !== AW'(2)) begin
      n_fail++;
      $display("FAIL mid_reset_row2: got rd_en=%b addr=%0d expected 1 / 2", rd_en_a, addr_a);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({obs_ctrl(), addr_a, wr_a, addr_b, wr_b} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %b expected all zero", {obs_ctrl(), addr_a, wr_a, addr_b, wr_b});
    end
    @(posedge clk); #1;
    reset   = 1'b1;
    exp_err = 1'b0;
    idle_cycles("mid_reset_after", 8);
    clear_plan();
    run_job("post_reset_job", 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_random_hold();
    test_start_while_busy();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
